// File: rtl/wb_scoreboard_pkg.sv
// Shared widths and write-back payload type for the write-back scoreboard.
package wb_scoreboard_pkg;

    localparam int unsigned WB_ADDRESS_WIDTH = 5;
    localparam int unsigned WB_DATA_WIDTH    = 32;

    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue / result / register-file write-back bundle of the scoreboard.
interface wb_scoreboard_if #(
    parameter int unsigned ADDRESS_WIDTH = wb_scoreboard_pkg::WB_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = wb_scoreboard_pkg::WB_DATA_WIDTH
);
    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_rd;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic                     stall;

    logic                     alu_valid;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     lsu_valid;
    logic [ADDRESS_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0]    lsu_data;
    logic                     lsu_ready;

    logic                     WE3;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic [DATA_WIDTH-1:0]    WD3;

    logic                     fwd1_en;
    logic                     fwd2_en;
    logic [DATA_WIDTH-1:0]    fwd_data;

    modport master (
        output issue_valid, issue_rd, rs1, rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  stall, lsu_ready, WE3, AD3, WD3, fwd1_en, fwd2_en, fwd_data
    );

    modport slave (
        input  issue_valid, issue_rd, rs1, rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output stall, lsu_ready, WE3, AD3, WD3, fwd1_en, fwd2_en, fwd_data
    );

endinterface

// File: rtl/wb_skid_buf.sv
// One-entry valid/ready holding register for long-latency results awaiting the write port.
module wb_skid_buf
    import wb_scoreboard_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  entry_t in_entry,
    output logic   in_ready_c,
    output logic   out_valid,
    output entry_t out_entry,
    input  logic   out_pop
);

    // Accept only into an empty slot, so a load and a pop never coincide.
    assign in_ready_c = !out_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_entry <= '0;
        end else if (in_valid && in_ready_c) begin
            out_valid <= 1'b1;
            out_entry <= in_entry;
        end else if (out_pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register busy-tracking scoreboard with ALU/LSU write-back arbitration.
// Optional write-port bypass to rs1/rs2 enabled by defining WB_BYPASS_EN.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH
) (
    input logic           clk,
    input logic           rst,
    wb_scoreboard_if.slave sb
);

    localparam int unsigned NREGS = 1 << ADDRESS_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             stall_c;
    logic             issue_ok_c;
    logic             fwd1_c;
    logic             fwd2_c;

    entry_t           lsu_entry;
    entry_t           buf_entry;
    logic             buf_valid;
    logic             buf_pop_c;
    logic             lsu_ready_c;

    entry_t           sel_entry;
    logic             sel_valid;
    logic             sel_write;

    assign lsu_entry = '{rd: sb.lsu_rd, data: sb.lsu_data};

    // ALU owns the write port whenever it is valid; the buffer drains otherwise.
    assign buf_pop_c = !sb.alu_valid;

    wb_skid_buf #(
        .entry_t (entry_t)
    ) u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (sb.lsu_valid),
        .in_entry   (lsu_entry),
        .in_ready_c (lsu_ready_c),
        .out_valid  (buf_valid),
        .out_entry  (buf_entry),
        .out_pop    (buf_pop_c)
    );

    assign sb.lsu_ready = lsu_ready_c;

`ifdef WB_BYPASS_EN
    assign fwd1_c      = sb.WE3 && (sb.AD3 != '0) && (sb.AD3 == sb.rs1);
    assign fwd2_c      = sb.WE3 && (sb.AD3 != '0) && (sb.AD3 == sb.rs2);
    assign sb.fwd_data = sb.WD3;
`else
    assign fwd1_c      = 1'b0;
    assign fwd2_c      = 1'b0;
    assign sb.fwd_data = '0;
`endif

    assign sb.fwd1_en = fwd1_c;
    assign sb.fwd2_en = fwd2_c;

    // Hazard detection; busy_q[0] is held at 0 so x0 never blocks.
    always_comb begin
        stall_c = 1'b0;
        if (sb.issue_valid) begin
            stall_c = (busy_q[sb.rs1] && !fwd1_c)
                   || (busy_q[sb.rs2] && !fwd2_c)
                   ||  busy_q[sb.issue_rd];
        end
    end

    assign sb.stall   = stall_c;
    assign issue_ok_c = sb.issue_valid && !stall_c && (sb.issue_rd != '0);

    // Retire clears first so a same-edge issue to that index wins.
    always_comb begin
        busy_d = busy_q;
        if (sb.WE3) begin
            busy_d[sb.AD3] = 1'b0;
        end
        if (issue_ok_c) begin
            busy_d[sb.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_entry = '0;
        if (sb.alu_valid) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: sb.alu_rd, data: sb.alu_data};
        end else if (buf_valid) begin
            sel_valid = 1'b1;
            sel_entry = buf_entry;
        end
    end

    assign sel_write = sel_valid && (sel_entry.rd != '0);

    // Write port: x0 results are dropped and AD3/WD3 keep their last written values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            sb.WE3 <= 1'b0;
            sb.AD3 <= '0;
            sb.WD3 <= '0;
        end else begin
            busy_q <= busy_d;
            sb.WE3 <= sel_write;
            if (sel_write) begin
                sb.AD3 <= sel_entry.rd;
                sb.WD3 <= sel_entry.data;
            end
        end
    end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register index width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 issue_valid  input  1  instruction issuing this cycle.
REQ-006 issue_rd  input  ADDRESS_WIDTH  destination of issuing instruction.
REQ-007 rs1, rs2  input  ADDRESS_WIDTH  source indices of issuing instruction.
REQ-008 stall  output  1  issue blocked by hazard (combinational).
REQ-009 alu_valid, alu_rd, alu_data  input  1/ADDRESS_WIDTH/DATA_WIDTH  single-cycle result; no backpressure.
REQ-010 lsu_valid, lsu_rd, lsu_data  input  1/ADDRESS_WIDTH/DATA_WIDTH  long-latency result.
REQ-011 lsu_ready  output  1  LSU result accepted when lsu_valid && lsu_ready.
REQ-012 WE3, AD3, WD3  output  1/ADDRESS_WIDTH/DATA_WIDTH  registered register-file write port.
REQ-013 fwd1_en, fwd2_en, fwd_data  output  1/1/DATA_WIDTH  bypass to rs1/rs2.

Function
REQ-014 Busy vector: one bit per register; bit 0 permanently 0.
REQ-015 issue_valid && !stall && issue_rd!=0 sets busy[issue_rd] at the next edge.
REQ-016 stall = issue_valid && (busy[rs1] || busy[rs2] || busy[issue_rd]), excluding any index 0 and any bypassed index per REQ-027.
REQ-017 Holding buffer: one entry {rd,data}; lsu_ready = !buf_valid && !rst.
REQ-018 LSU handshake accepted at cycle N loads buffer; buf_valid high from N+1.
REQ-019 Output stage load each edge: alu_valid -> {alu_rd,alu_data}; else buf_valid -> buffer contents, buffer cleared; else WE3<=0.
REQ-020 ALU always has priority; buffer holds while alu_valid, lsu_ready stays 0.
REQ-021 WE3 asserted only if selected rd != 0; write to x0 dropped, no busy change.
REQ-022 Latency: ALU result cycle N -> WE3 in N+1; LSU accept N, no ALU in N+1 -> WE3 in N+2.
REQ-023 busy[AD3] cleared at the edge ending any cycle with WE3=1.
REQ-024 Same-edge set (REQ-015) and clear (REQ-023) of one index: set wins.
REQ-025 AD3/WD3 hold last values when WE3=0.

Reset
REQ-026 rst at any edge, including with buffer full or busy bits set: busy all 0, buf_valid 0, WE3 0, AD3 0, WD3 0; pending LSU result discarded; lsu_ready 0 while rst high, 1 in first cycle after.

Configuration
REQ-027 Macro WB_BYPASS_EN defined: fwdN_en = WE3 && AD3!=0 && AD3==rsN; fwd_data = WD3; stall ignores busy[rsN] when fwdN_en.
REQ-028 WB_BYPASS_EN undefined: fwd1_en, fwd2_en, fwd_data tied 0; stall per REQ-016 without exemption.

Structure
REQ-029 Shared package holds ADDRESS_WIDTH/DATA_WIDTH defaults and wb_entry_t struct {rd, data}.
REQ-030 Holding buffer is sub-module wb_skid_buf (one-entry valid/ready register).

Verification
REQ-031 alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle 0 -> WE3=1, AD3=5, WD3=0xDEADBEEF at cycle 1.
REQ-032 Issue rd=7; next cycle rs1=7 -> stall=1; LSU result rd=7 -> after WE3 cycle, busy[7]=0 and stall=0 (with WB_BYPASS_EN, stall=0 and fwd1_en=1, fwd_data=LSU value during WE3 cycle).
REQ-033 lsu_valid and alu_valid both high 3 cycles -> ALU writes 3 cycles, lsu_ready=0 cycles 1-3, LSU write in cycle 4.
REQ-034 alu_rd=0, alu_data=0x1 -> WE3=0; issue_rd=0 never stalls.
REQ-035 LSU accepted, rst asserted next cycle -> no WE3 for that entry; busy all 0 after reset.
REQ-036 Issue rd=9 in same cycle as WE3 with AD3=9 -> busy[9]=1 afterwards.
